// File: rtl/logiprobe_trigger.sv
// Trigger and sample-strobe generator feeding the on-chip logic probe.
// Masked pattern match, optional single-channel edge qualifier, hit counting and post-trigger delay.
module logiprobe_trigger #(
    parameter int W  = 128,
    parameter int SW = 7,
    parameter int CW = 16
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          arm,
    input  logic [W-1:0]  channels,
    input  logic [W-1:0]  match_value,
    input  logic [W-1:0]  match_mask,
    input  logic          edge_en,
    input  logic [SW-1:0] edge_sel,
    input  logic          edge_rising,
    input  logic [CW-1:0] match_count,
    input  logic [CW-1:0] delay,
    input  logic [CW-1:0] sample_div,
    output logic          sample,
    output logic          trigger,
    output logic          armed,
    output logic          fired
);

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_ARMED = 2'd1;
    localparam logic [1:0] ST_DELAY = 2'd2;
    localparam logic [1:0] ST_FIRED = 2'd3;

    logic [1:0]    state_reg, state_next;
    logic [CW-1:0] div_cnt_reg;
    logic [CW-1:0] hitcnt_reg, hitcnt_next;
    logic [CW-1:0] delcnt_reg, delcnt_next;
    logic [CW-1:0] match_cap_reg, match_cap_next;
    logic [CW-1:0] delay_cap_reg, delay_cap_next;
    logic          prev_reg, prev_next;
    logic          prev_valid_reg, prev_valid_next;
    logic          sample_reg, trigger_reg, armed_reg;

    logic          tick;
    logic [W-1:0]  diff;
    logic          pmatch;
    logic          sel_ok;
    logic          cur;
    logic          edge_seen;
    logic          hit;
    logic          searching;

    // A terminal comparison of >= lets a shrinking sample_div take effect immediately.
    assign tick = (div_cnt_reg >= sample_div);

    for (genvar gi = 0; gi < W; gi++) begin : g_diff
        assign diff[gi] = (channels[gi] ^ match_value[gi]) & match_mask[gi];
    end

    assign pmatch    = ~|diff;
    assign sel_ok    = (32'(edge_sel) < W);
    assign cur       = sel_ok ? channels[edge_sel] : 1'b0;
    assign edge_seen = prev_valid_reg & sel_ok &
                       (edge_rising ? (~prev_reg & cur) : (prev_reg & ~cur));
    assign hit       = tick & pmatch & (edge_en ? edge_seen : 1'b1);
    assign searching = (state_reg == ST_ARMED) || (state_reg == ST_DELAY);

    always_comb begin
        state_next      = state_reg;
        hitcnt_next     = hitcnt_reg;
        delcnt_next     = delcnt_reg;
        match_cap_next  = match_cap_reg;
        delay_cap_next  = delay_cap_reg;
        prev_next       = prev_reg;
        prev_valid_next = prev_valid_reg;
        if (arm) begin
            // Arm overrides everything, including a hit in the same cycle.
            state_next      = ST_ARMED;
            hitcnt_next     = '0;
            prev_valid_next = 1'b0;
            match_cap_next  = match_count;
            delay_cap_next  = delay;
        end else begin
            if (searching && tick) begin
                prev_next       = cur;
                prev_valid_next = 1'b1;
            end
            case (state_reg)
                ST_ARMED: begin
                    if (hit) begin
                        if (hitcnt_reg == match_cap_reg) begin
                            if (delay_cap_reg == '0) begin
                                state_next = ST_FIRED;
                            end else begin
                                state_next  = ST_DELAY;
                                delcnt_next = delay_cap_reg;
                            end
                        end else begin
                            hitcnt_next = hitcnt_reg + CW'(1);
                        end
                    end
                end
                ST_DELAY: begin
                    if (tick) begin
                        if (delcnt_reg == CW'(1)) begin
                            state_next = ST_FIRED;
                        end else begin
                            delcnt_next = delcnt_reg - CW'(1);
                        end
                    end
                end
                default: begin
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_reg      <= ST_IDLE;
            div_cnt_reg    <= '0;
            hitcnt_reg     <= '0;
            delcnt_reg     <= '0;
            match_cap_reg  <= '0;
            delay_cap_reg  <= '0;
            prev_reg       <= 1'b0;
            prev_valid_reg <= 1'b0;
            sample_reg     <= 1'b0;
            trigger_reg    <= 1'b0;
            armed_reg      <= 1'b0;
        end else begin
            state_reg      <= state_next;
            div_cnt_reg    <= tick ? '0 : div_cnt_reg + CW'(1);
            hitcnt_reg     <= hitcnt_next;
            delcnt_reg     <= delcnt_next;
            match_cap_reg  <= match_cap_next;
            delay_cap_reg  <= delay_cap_next;
            prev_reg       <= prev_next;
            prev_valid_reg <= prev_valid_next;
            sample_reg     <= tick;
            trigger_reg    <= (state_next == ST_FIRED);
            armed_reg      <= (state_next == ST_ARMED) || (state_next == ST_DELAY);
        end
    end

    assign sample  = sample_reg;
    assign trigger = trigger_reg;
    assign fired   = trigger_reg;
    assign armed   = armed_reg;

endmodule

// File: tb/tb_logiprobe_trigger.sv
// Bench for logiprobe_trigger: directed scenarios plus randomized transactions,
// every cycle compared against a hits-remaining / ticks-remaining reference model.
module tb_logiprobe_trigger;

    localparam int W  = 128;
    localparam int SW = 7;
    localparam int CW = 16;

    logic          clock = 1'b0;
    logic          reset;
    logic          arm;
    logic [W-1:0]  channels;
    logic [W-1:0]  match_value;
    logic [W-1:0]  match_mask;
    logic          edge_en;
    logic [SW-1:0] edge_sel;
    logic          edge_rising;
    logic [CW-1:0] match_count;
    logic [CW-1:0] delay;
    logic [CW-1:0] sample_div;
    logic          sample, trigger, armed, fired;

    int total = 0;
    int bad   = 0;

    // reference model state
    int m_phase;
    bit m_active;
    bit m_fired;
    int m_hits_left;
    int m_ticks_left;
    int m_delay;
    bit m_prev;
    bit m_prev_valid;
    bit m_sample;

    logic last_trig;

    logiprobe_trigger #(.W(W), .SW(SW), .CW(CW)) dut (
        .clock       (clock),
        .reset       (reset),
        .arm         (arm),
        .channels    (channels),
        .match_value (match_value),
        .match_mask  (match_mask),
        .edge_en     (edge_en),
        .edge_sel    (edge_sel),
        .edge_rising (edge_rising),
        .match_count (match_count),
        .delay       (delay),
        .sample_div  (sample_div),
        .sample      (sample),
        .trigger     (trigger),
        .armed       (armed),
        .fired       (fired)
    );

    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0h expected=%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Behaviour of one clock edge, using the inputs present at that edge.
    task automatic model_edge();
        bit tick, pm, cur, edge_ok, hit;
        if (reset) begin
            m_phase = 0; m_active = 0; m_fired = 0; m_sample = 0;
            m_prev = 0; m_prev_valid = 0; m_hits_left = 0; m_ticks_left = 0;
            return;
        end
        tick     = (m_phase >= int'(sample_div));
        m_phase  = tick ? 0 : m_phase + 1;
        m_sample = tick;
        pm       = (((channels ^ match_value) & match_mask) == '0);
        cur      = channels[edge_sel];
        if (arm) begin
            m_active     = 1;
            m_fired      = 0;
            m_hits_left  = int'(match_count) + 1;
            m_delay      = int'(delay);
            m_ticks_left = 0;
            m_prev_valid = 0;
        end else if (m_active && tick) begin
            edge_ok = m_prev_valid && (edge_rising ? (!m_prev && cur) : (m_prev && !cur));
            m_prev = cur;
            m_prev_valid = 1;
            if (m_ticks_left == 0) begin
                hit = pm && (!edge_en || edge_ok);
                if (hit) begin
                    m_hits_left--;
                    if (m_hits_left == 0) begin
                        if (m_delay == 0) begin
                            m_active = 0; m_fired = 1;
                        end else begin
                            m_ticks_left = m_delay;
                        end
                    end
                end
            end else begin
                m_ticks_left--;
                if (m_ticks_left == 0) begin
                    m_active = 0; m_fired = 1;
                end
            end
        end
    endtask

    task automatic cyc();
        last_trig = trigger;
        @(posedge clock);
        model_edge();
        #1;
        chk("sample",  sample,  m_sample);
        chk("trigger", trigger, m_fired);
        chk("fired",   fired,   m_fired);
        chk("armed",   armed,   m_active);
    endtask

    task automatic pulse_arm();
        arm = 1'b1;
        cyc();
        arm = 1'b0;
    endtask

    initial begin
        reset = 1'b1; arm = 1'b0; channels = '0; match_value = '0; match_mask = '0;
        edge_en = 1'b0; edge_sel = '0; edge_rising = 1'b1;
        match_count = '0; delay = '0; sample_div = '0;

        // basic fire, no qualification
        repeat (3) cyc();
        chk("rst_trigger", trigger, 0);
        chk("rst_sample",  sample,  0);
        chk("rst_armed",   armed,   0);
        reset = 1'b0;
        repeat (9) cyc();
        pulse_arm();
        chk("t1_armed", armed, 1);
        repeat (3) cyc();
        chk("t1_trig", trigger, 1);
        chk("t1_samp", sample, 1);
        $display("basic: trigger=%0b sample=%0b", trigger, sample);

        // divided sample rate; trigger must coincide with a strobe
        sample_div = 16'd3;
        pulse_arm();
        for (int i = 0; i < 12; i++) begin
            cyc();
            if (trigger && !last_trig) chk("t2_coinc", sample, 1);
        end
        $display("divider: trigger=%0b", trigger);

        // pattern count: fire on the third 0x5A
        sample_div = 16'd0;
        match_mask = 128'hFF; match_value = 128'h5A; match_count = 16'd2;
        channels = '0;
        pulse_arm();
        channels[7:0] = 8'h5A; cyc();
        channels[7:0] = 8'h00; cyc();
        channels[7:0] = 8'h5A; cyc();
        channels[7:0] = 8'h00; cyc();
        chk("t3_early", trigger, 0);
        channels[7:0] = 8'h5A; cyc();
        chk("t3_fire", trigger, 1);
        $display("pattern: trigger=%0b", trigger);

        // rising edge on channel 100
        match_mask = '0; match_count = '0;
        edge_en = 1'b1; edge_sel = 7'd100; edge_rising = 1'b1;
        channels = '0; channels[100] = 1'b1;
        pulse_arm();
        repeat (3) cyc();
        channels[100] = 1'b0; repeat (2) cyc();
        chk("t4_nofire", trigger, 0);
        channels[100] = 1'b1; cyc();
        chk("t4_fire", trigger, 1);
        $display("edge: trigger=%0b", trigger);

        // post-trigger delay, then re-arm in the middle of the delay
        edge_en = 1'b0; sample_div = 16'd1; delay = 16'd5;
        pulse_arm();
        repeat (14) cyc();
        chk("t5_fire", trigger, 1);
        pulse_arm();
        repeat (4) cyc();
        pulse_arm();
        repeat (2) cyc();
        chk("t5_rearm_armed", armed, 1);
        chk("t5_rearm_trig", trigger, 0);
        repeat (14) cyc();
        $display("delay: trigger=%0b", trigger);

        // fire, re-arm on an impossible pattern, reset while armed
        delay = '0; sample_div = '0; match_mask = '0;
        pulse_arm();
        repeat (2) cyc();
        match_mask = '1; match_value = ~channels;
        pulse_arm();
        chk("t6_drop", trigger, 0);
        repeat (40) cyc();
        chk("t6_armed", armed, 1);
        reset = 1'b1; cyc();
        chk("t6_rst_armed", armed, 0);
        chk("t6_rst_trig",  trigger, 0);
        reset = 1'b0;
        $display("rearm/reset: armed=%0b trigger=%0b", armed, trigger);

        // randomized transactions
        for (int t = 0; t < 40; t++) begin
            sample_div  = CW'($urandom_range(0, 3));
            match_count = CW'($urandom_range(0, 3));
            delay       = CW'($urandom_range(0, 3));
            edge_en     = 1'($urandom_range(0, 1));
            edge_rising = 1'($urandom_range(0, 1));
            edge_sel    = SW'($urandom_range(0, W - 1));
            match_mask  = '0;
            match_mask[3:0] = 4'($urandom);
            match_value = {$urandom, $urandom, $urandom, $urandom};
            pulse_arm();
            for (int i = 0; i < 60; i++) begin
                channels = {$urandom, $urandom, $urandom, $urandom};
                arm = ($urandom_range(0, 49) == 0);
                cyc();
            end
            arm = 1'b0;
            $display("txn %0d div=%0d mc=%0d dly=%0d edge_en=%0b sel=%0d trig=%0b armed=%0b",
                     t, sample_div, match_count, delay, edge_en, edge_sel, trigger, armed);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/logiprobe_trigger.md
Name: logiprobe_trigger

Overview:
- Trigger and sample-strobe generator that sits directly upstream of the on-chip logic probe.
- Produces the probe's `trigger` and `sample` inputs from the same 128 channels the probe captures.
- Trigger condition: masked pattern match, optionally qualified by an edge on one selected channel, counted over N occurrences, then delayed by M sample periods.
- Sample is a programmable-rate strobe, so slow events can be traced with a 512-deep memory.

Parameters:
- W, 128, channel width; must equal the probe's channel count.
- SW, 7, width of edge_sel; SW = ceil(log2(W)).
- CW, 16, width of match_count, delay, sample_div and their internal counters.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- arm  in  1  one-cycle pulse; (re)starts trigger search.
- channels  in  W  live signals under observation; same vector wired to the probe.
- match_value  in  W  required value of the masked channels.
- match_mask  in  W  1 = bit participates in the match; all-zero = always match.
- edge_en  in  1  1 = additionally require an edge on channels[edge_sel].
- edge_sel  in  SW  channel index for edge qualification; values >= W never qualify.
- edge_rising  in  1  1 = rising edge (0 to 1); 0 = falling edge (1 to 0).
- match_count  in  CW  number of hits to skip; fire on hit number match_count+1.
- delay  in  CW  sample periods between the final hit and fire.
- sample_div  in  CW  sample strobe period = sample_div+1 clocks.
- sample  out  1  registered one-cycle strobe to the probe.
- trigger  out  1  registered level to the probe; high while in FIRED.
- armed  out  1  high in ARMED or DELAY.
- fired  out  1  equals trigger; status/LED use.

Behaviour:
- Reset: sample=0, trigger=0, armed=0, fired=0; state IDLE; all counters 0; prev_valid=0.
- Sample divider:
  - Free-running from reset, independent of state.
  - Counter counts 0..sample_div; at terminal value it wraps to 0 and the registered sample goes high for the next cycle.
  - sample_div=0: sample high every cycle from the 2nd cycle after reset release.
  - If sample_div changes below the current count, the counter wraps at the next terminal comparison (count >= sample_div is terminal).
- Sample qualification: internal tick = cycle where the divider reaches terminal. Channels are evaluated only on ticks, so decisions align with the sample pulse that follows.
- Pattern: pmatch = (((channels ^ match_value) & match_mask) == 0).
- Edge detection:
  - prev = channels[edge_sel] latched on every tick while ARMED or DELAY.
  - prev_valid is set on the first such tick after arm.
  - rising: prev_valid & !prev & cur. Falling: prev_valid & prev & !cur.
- hit = tick & pmatch & (edge_en ? edge : 1).
- Capture at arm: match_count and delay are latched on the arm cycle. match_value, match_mask, edge_* and sample_div are used live and must be held stable by the user while armed.
- IDLE: outputs low. arm goes to ARMED; hitcnt=0, prev_valid=0.
- ARMED:
  - On hit with hitcnt==match_cap: go to FIRED if delay_cap==0; otherwise go to DELAY with delcnt=delay_cap.
  - On hit with hitcnt<match_cap: hitcnt+1.
  - Non-hit cycles: hold.
- DELAY: on each tick, if delcnt==1 go to FIRED, else delcnt-1. Pattern and edge are ignored.
- FIRED:
  - trigger=fired=1, armed=0; held until reset or arm.
  - The probe latches trigger once per its own reset, so holding the level is safe.
- arm in any state, including mid-DELAY or FIRED: restart as from IDLE. trigger drops on the next cycle.
- Simultaneous arm and hit: arm wins; that hit is not counted.
- Latency:
  - trigger rises 1 clock after the deciding hit or delay tick.
  - sample rises 1 clock after the tick, so trigger and the first post-decision sample pulse are coincident. The probe therefore captures the decision-cycle data as sample 0.
- Counters never wrap. hitcnt saturates by construction (it stops at match_cap). delcnt stops at 1.

Test Plan:
- Reset, sample_div=0, mask=0, match_count=0, delay=0, arm at cycle 10 -> armed=1 at cycle 11; hit at cycle 11; trigger=1 at cycle 12 and held; sample=1 every cycle.
- sample_div=3, arm, channels stable -> sample high exactly every 4th clock; trigger edge coincides with a sample pulse.
- mask=0xFF, value=0x5A, match_count=2, channels[7:0] toggles 0x5A/0x00 on every tick -> trigger only after the 3rd 0x5A tick; no trigger on the 1st or 2nd.
- edge_en=1, edge_sel=100, rising, mask=0; channel 100 held high at arm, then falls, then rises -> no fire on the initial high level or the fall; fire on the rise.
- delay=5, sample_div=1, match on the first tick -> DELAY for 5 ticks (10 clocks); trigger 1 clock after the 5th tick; arm pulsed during DELAY in a second run -> returns to ARMED, trigger stays 0.
- Fire, then arm with mask=all-ones and value never present -> trigger drops next cycle, armed=1 indefinitely; reset mid-ARMED -> all outputs 0 on the next clock.
